// File: rtl/ov7670_pkg.sv
// Shared types and constants for the OV7670-style DVP test-pattern generator.
// RGB444 colours are packed {R,G,B}, one nibble each.
package ov7670_pkg;

  typedef enum logic [2:0] {
    IDLE,
    VSYNC,
    VBACK,
    ACTIVE,
    HBLANK,
    VFRONT
  } state_t;

  localparam logic [1:0] MODE_FULL   = 2'd0;
  localparam logic [1:0] MODE_TOP    = 2'd1;
  localparam logic [1:0] MODE_BOTTOM = 2'd2;
  localparam logic [1:0] MODE_NONE   = 2'd3;

  localparam logic [11:0] YELLOW     = 12'hFF0;
  localparam logic [11:0] BACKGROUND = 12'h111;

  function automatic int imax(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  // xR/GB byte order: the even byte carries red, the odd byte green and blue.
  function automatic logic [7:0] rgb444_byte(input logic [11:0] rgb, input logic odd_byte);
    return odd_byte ? rgb[7:0] : {4'h0, rgb[11:8]};
  endfunction

endpackage

// File: rtl/ov7670_stream_gen_timing.sv
// Frame/line timing FSM: walks VSYNC, VBACK, ACTIVE/HBLANK pairs and VFRONT,
// exposing the byte column and active line for the pixel path in the top.
module dvp_timing_gen
  import ov7670_pkg::*;
#(
  parameter int H_ACTIVE  = 320,
  parameter int V_ACTIVE  = 240,
  parameter int H_BLANK   = 144,
  parameter int VS_LINES  = 3,
  parameter int VBP_LINES = 17,
  parameter int VFP_LINES = 10
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        enable,
  output logic [2:0]  state,
  output logic [10:0] col,
  output logic [9:0]  line,
  output logic        seg_last,
  output logic        start
);

  localparam int LINE_LEN = 2 * H_ACTIVE + H_BLANK;
  localparam int VS_LEN   = VS_LINES * LINE_LEN;
  localparam int VBP_LEN  = VBP_LINES * LINE_LEN;
  localparam int VFP_LEN  = VFP_LINES * LINE_LEN;
  localparam int ACT_LEN  = 2 * H_ACTIVE;
  localparam int MAX_LEN  = imax(imax(VS_LEN, VBP_LEN), imax(VFP_LEN, LINE_LEN));
  localparam int CW       = $clog2(MAX_LEN + 1);

  state_t        st;
  logic [CW-1:0] cnt;

  assign state = st;
  assign col   = 11'(cnt);

  // NOTE: a combinational block assigns a default before any branch so no latch is inferred.
  always_comb begin
    seg_last = 1'b0;
    case (st)
      VSYNC:   seg_last = (cnt == CW'(VS_LEN - 1));
      VBACK:   seg_last = (cnt == CW'(VBP_LEN - 1));
      ACTIVE:  seg_last = (cnt == CW'(ACT_LEN - 1));
      HBLANK:  seg_last = (cnt == CW'(H_BLANK - 1));
      VFRONT:  seg_last = (cnt == CW'(VFP_LEN - 1));
      default: seg_last = 1'b0;
    endcase
  end

  // A frame begins from IDLE or directly from the last front-porch clock.
  assign start = enable && ((st == IDLE) || ((st == VFRONT) && seg_last));

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      st   <= IDLE;
      cnt  <= '0;
      line <= '0;
    end else begin
      if (st == IDLE || seg_last) cnt <= '0;
      else                        cnt <= cnt + CW'(1);

      case (st)
        IDLE:   if (enable) st <= VSYNC;
        VSYNC:  if (seg_last) st <= VBACK;
        VBACK:  if (seg_last) begin
                  st   <= ACTIVE;
                  line <= '0;
                end
        ACTIVE: if (seg_last) st <= HBLANK;
        HBLANK: if (seg_last) begin
                  line <= line + 10'd1;
                  st   <= (line == 10'(V_ACTIVE - 1)) ? VFRONT : ACTIVE;
                end
        VFRONT: if (seg_last) st <= enable ? VSYNC : IDLE;
        default: st <= IDLE;
      endcase
    end
  end

endmodule

// File: rtl/ov7670_stream_gen.sv
// OV7670-style RGB444 test stream with a configurable yellow vertical stripe.
// All outputs are registered from the timing state, so they move together.
module ov7670_stream_gen
  import ov7670_pkg::*;
#(
  parameter int H_ACTIVE  = 320,
  parameter int V_ACTIVE  = 240,
  parameter int H_BLANK   = 144,
  parameter int VS_LINES  = 3,
  parameter int VBP_LINES = 17,
  parameter int VFP_LINES = 10,
  parameter int STRIPE_W  = 16
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       enable,
  input  logic [8:0] stripe_x,
  input  logic [1:0] mode,
  output logic       vsync,
  output logic       href,
  output logic [7:0] d,
  output logic       frame_done,
  output logic       busy
);

  logic [2:0]  state_bits;
  logic [10:0] col;
  logic [9:0]  line;
  logic        seg_last;
  logic        start;
  state_t      st;

  dvp_timing_gen #(
    .H_ACTIVE (H_ACTIVE),
    .V_ACTIVE (V_ACTIVE),
    .H_BLANK  (H_BLANK),
    .VS_LINES (VS_LINES),
    .VBP_LINES(VBP_LINES),
    .VFP_LINES(VFP_LINES)
  ) u_timing (
    .clk     (clk),
    .reset_n (reset_n),
    .enable  (enable),
    .state   (state_bits),
    .col     (col),
    .line    (line),
    .seg_last(seg_last),
    .start   (start)
  );

  assign st = state_t'(state_bits);

  logic [8:0] sx_q;
  logic [1:0] mode_q;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      sx_q   <= '0;
      mode_q <= MODE_FULL;
    end else if (start) begin
      sx_q   <= stripe_x;
      mode_q <= mode;
    end
  end

  // Column compare is 10 bits wide so stripe_x + STRIPE_W - 1 never wraps.
  logic [9:0]  px;
  logic [9:0]  sx_lo;
  logic [9:0]  sx_hi;
  logic        in_cols;
  logic        line_ok;
  logic [11:0] rgb;
  logic [7:0]  pix_byte;

  assign px      = col[10:1];
  assign sx_lo   = {1'b0, sx_q};
  assign sx_hi   = sx_lo + 10'(STRIPE_W - 1);
  assign in_cols = (px >= sx_lo) && (px <= sx_hi) && (px < 10'(H_ACTIVE));

  always_comb begin
    line_ok = 1'b0;
    case (mode_q)
      MODE_FULL:   line_ok = 1'b1;
      MODE_TOP:    line_ok = (line < 10'(V_ACTIVE / 2));
      MODE_BOTTOM: line_ok = (line >= 10'(V_ACTIVE / 2));
      default:     line_ok = 1'b0;
    endcase
  end

  assign rgb      = (in_cols && line_ok) ? YELLOW : BACKGROUND;
  assign pix_byte = rgb444_byte(rgb, col[0]);

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      vsync      <= 1'b0;
      href       <= 1'b0;
      d          <= 8'h00;
      frame_done <= 1'b0;
      busy       <= 1'b0;
    end else begin
      vsync      <= (st == VSYNC);
      href       <= (st == ACTIVE);
      d          <= (st == ACTIVE) ? pix_byte : 8'h00;
      frame_done <= (st == VFRONT) && seg_last;
      busy       <= (st != IDLE);
    end
  end

endmodule

// File: tb/tb_ov7670_stream_gen.sv
// Self-checking bench: every output clock of each frame is compared against a
// per-clock reference computed from frame position, stripe config and mode.
module tb_ov7670_stream_gen;

  localparam int FRAME = 140;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       enable;
  logic [8:0] stripe_x;
  logic [1:0] mode;
  logic       vsync;
  logic       href;
  logic [7:0] d;
  logic       frame_done;
  logic       busy;

  int checks   = 0;
  int failures = 0;

  ov7670_stream_gen #(
    .H_ACTIVE (8),
    .V_ACTIVE (4),
    .H_BLANK  (4),
    .VS_LINES (1),
    .VBP_LINES(1),
    .VFP_LINES(1),
    .STRIPE_W (2)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .enable    (enable),
    .stripe_x  (stripe_x),
    .mode      (mode),
    .vsync     (vsync),
    .href      (href),
    .d         (d),
    .frame_done(frame_done),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  function automatic logic [11:0] outs();
    return {vsync, href, d, frame_done, busy};
  endfunction

  task automatic check(input string tag, input logic [11:0] got, input logic [11:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s t=%0t got=%h exp=%h ({vsync,href,d,frame_done,busy})", tag, $time, got, exp);
    end
  endtask

  // Reference: 20-clock line periods; period 0 vsync, 1 back porch,
  // 2..5 active lines (16 bytes then 4 blank), 6 front porch.
  function automatic logic [11:0] exp_out(input int t, input int sx, input int md);
    int p, w, x, ln;
    logic hr, yel, ln_ok;
    logic [7:0] dd;
    p  = t / 20;
    w  = t % 20;
    ln = p - 2;
    hr = (p >= 2) && (p <= 5) && (w < 16);
    dd = 8'h00;
    if (hr) begin
      x = w / 2;
      if (md == 1)      ln_ok = (ln < 2);
      else if (md == 2) ln_ok = (ln >= 2);
      else              ln_ok = (md == 0);
      yel = ln_ok && (x >= sx) && (x <= sx + 1) && (x < 8);
      if (w % 2 == 0) dd = yel ? 8'h0F : 8'h01;
      else            dd = yel ? 8'hF0 : 8'h11;
    end
    return {(p == 0), hr, dd, (t == FRAME - 1), 1'b1};
  endfunction

  // Waits for a frame start, compares every clock of it, and loads the next
  // frame's config during the front porch. poke_kind: 1 stripe_x, 2 drop
  // enable, 3 reset (aborts the frame).
  task automatic run_frame(input int sx, input int md, input int nsx, input int nmd,
                           input int poke_t, input int poke_kind, input int poke_val,
                           input int exp_gap);
    int waited;
    waited = 0;
    do begin
      @(posedge clk); #1;
      waited++;
    end while (!vsync && waited < 400);
    if (!vsync) begin
      check("vsync_timeout", 12'h000, 12'h001);
      return;
    end
    if (exp_gap > 0) check("frame_gap", 12'(waited), 12'(exp_gap));
    for (int t = 0; t < FRAME; t++) begin
      if (t > 0) begin
        @(posedge clk); #1;
      end
      check("stream", outs(), exp_out(t, sx, md));
      if (t == 125) begin
        stripe_x = 9'(nsx);
        mode     = 2'(nmd);
      end
      if (t == poke_t) begin
        case (poke_kind)
          1: stripe_x = 9'(poke_val);
          2: enable = 1'b0;
          3: begin
            reset_n = 1'b0;
            for (int i = 0; i < 3; i++) begin
              @(posedge clk); #1;
              check("reset_outs", outs(), 12'h000);
            end
            reset_n = 1'b1;
            enable  = 1'b0;
            for (int i = 0; i < 5; i++) begin
              @(posedge clk); #1;
              check("post_reset_idle", outs(), 12'h000);
            end
            return;
          end
          default: ;
        endcase
      end
    end
  endtask

  initial begin
    int csx, cmd, nsx, nmd;
    reset_n  = 1'b0;
    enable   = 1'b0;
    stripe_x = 9'd3;
    mode     = 2'd0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_state", outs(), 12'h000);
    reset_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      check("idle_no_enable", outs(), 12'h000);
    end

    enable = 1'b1;
    run_frame(3, 0, 3, 1, -1, 0, 0, 0);
    run_frame(3, 1, 3, 2, -1, 0, 0, 1);
    run_frame(3, 2, 7, 0, -1, 0, 0, 1);
    run_frame(7, 0, 9, 0, -1, 0, 0, 1);
    run_frame(9, 0, 3, 0, -1, 0, 0, 1);
    run_frame(3, 0, 5, 0, 65, 1, 5, 1);

    csx = 5;
    cmd = 0;
    for (int f = 0; f < 6; f++) begin
      nsx = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 511)) : int'($urandom_range(0, 11));
      nmd = int'($urandom_range(0, 3));
      run_frame(csx, cmd, nsx, nmd, -1, 0, 0, 1);
      csx = nsx;
      cmd = nmd;
    end

    run_frame(csx, cmd, csx, cmd, 50, 2, 0, 1);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      check("idle_after_drop", outs(), 12'h000);
    end

    stripe_x = 9'd3;
    mode     = 2'd0;
    enable   = 1'b1;
    run_frame(3, 0, 3, 0, 70, 3, 0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
